data_mem_bridge: RTL and testbench

- Sits directly downstream of the memory-access stage, between the pipeline's data-memory request signals and a word-wide, ack-handshaked data bus.
- Performs the following for pipeline loads and stores:
  - word-aligns the address;
  - generates byte enables and lane-replicated write data;
  - right-aligns read data;
  - stalls the pipeline while the bus is busy.
- Detects misaligned accesses, bus errors and bus timeouts, and reports them as a one-cycle fault.

---
 rtl/data_mem_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_data_mem_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
// data_mem_bridge
// Connects the pipeline's data-memory request signals to a word-wide,
// ack-handshaked bus. It word-aligns addresses, builds byte enables and
// lane-replicated store data, and right-aligns load data. It stalls the
// pipeline while a transfer is in flight. Misaligned accesses, bus errors
// and timeouts are reported as a one-cycle fault.
module data_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic [31:0] i_data_addr,
   input  logic [31:0] i_data_wr,
   input  logic [1:0]  i_data_rd_en_ctrl,
   input  logic        i_data_rd_en,
   input  logic        i_data_wr_en,
   output logic [31:0] o_data_rd,
   output logic        o_stall,
   output logic        o_fault,
   output logic [1:0]  o_fault_cause,
   output logic [31:0] o_fault_addr,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_be,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_err
);

   // Access size encoding on i_data_rd_en_ctrl
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Fault cause encoding
   localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   localparam logic [1:0] CAUSE_BUSERR  = 2'b11;

   // Last counter value before the timeout fires; unused when the timeout is disabled
   localparam logic [31:0] TIMEOUT_LAST =
      (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
   localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10,
      ERR  = 2'b11
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, addr_next;          // full byte address of the access
   logic [31:0] wdata_reg, wdata_next;
   logic [3:0]  be_reg, be_next;
   logic        we_reg, we_next;
   logic [31:0] cnt_reg, cnt_next;            // BUSY cycle counter for the timeout
   logic [31:0] data_rd_reg, data_rd_next;
   logic [1:0]  fault_cause_reg, fault_cause_next;
   logic [31:0] fault_addr_reg, fault_addr_next;

   logic        req;
   logic [1:0]  lane_sel;
   logic        misaligned;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_be;
   logic [31:0] rdata_aligned;
   logic        timeout_hit;

   assign req      = i_data_rd_en | i_data_wr_en;
   assign lane_sel = i_data_addr[1:0];

   // Reserved size, or a half/word not on its natural boundary
   always_comb begin
      misaligned = 1'b0;
      case (i_data_rd_en_ctrl)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = i_data_addr[0];
         SIZE_WORD: misaligned = (i_data_addr[1:0] != 2'b00);
         default:   misaligned = 1'b1;
      endcase
   end

   // Replicate store data across all byte lanes; the byte enables pick the live lanes
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_wdata[8*gi +: 8] =
            (i_data_rd_en_ctrl == SIZE_BYTE) ? i_data_wr[7:0] :
            (i_data_rd_en_ctrl == SIZE_HALF) ? i_data_wr[8*(gi % 2) +: 8] :
                                               i_data_wr[8*gi +: 8];
      end
   endgenerate

   // Byte enables for stores; only aligned sizes ever reach the bus
   always_comb begin
      lane_be = 4'b1111;
      case (i_data_rd_en_ctrl)
         SIZE_BYTE: lane_be = 4'b0001 << lane_sel;
         SIZE_HALF: lane_be = 4'b0011 << lane_sel;
         default:   lane_be = 4'b1111;
      endcase
   end

   // Bring the addressed byte down to bit 0, zero filling the top
   assign rdata_aligned = i_bus_rdata >> {addr_reg[1:0], 3'b000};

   assign timeout_hit = TIMEOUT_ON && (cnt_reg == TIMEOUT_LAST);

   // Next-state and register-update logic for the access FSM
   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      wdata_next       = wdata_reg;
      be_next          = be_reg;
      we_next          = we_reg;
      cnt_next         = cnt_reg;
      data_rd_next     = data_rd_reg;
      fault_cause_next = fault_cause_reg;
      fault_addr_next  = fault_addr_reg;

      case (state_reg)
         IDLE: begin
            cnt_next = 32'd0;
            if (req) begin
               if (misaligned) begin
                  state_next       = ERR;
                  fault_cause_next = CAUSE_ALIGN;
                  fault_addr_next  = i_data_addr;
               end else begin
                  // A simultaneous load and store is treated as a store
                  state_next = BUSY;
                  addr_next  = i_data_addr;
                  we_next    = i_data_wr_en;
                  wdata_next = i_data_wr_en ? lane_wdata : 32'd0;
                  be_next    = i_data_wr_en ? lane_be : 4'b1111;
               end
            end
         end

         BUSY: begin
            cnt_next = cnt_reg + 32'd1;
            if (i_bus_err) begin
               state_next       = ERR;
               fault_cause_next = CAUSE_BUSERR;
               fault_addr_next  = addr_reg;
            end else if (i_bus_ack) begin
               state_next   = DONE;
               data_rd_next = we_reg ? 32'd0 : rdata_aligned;
            end else if (timeout_hit) begin
               state_next       = ERR;
               fault_cause_next = CAUSE_TIMEOUT;
               fault_addr_next  = addr_reg;
            end
         end

         // The pipeline still presents the request here; it is not reissued
         DONE: state_next = IDLE;

         ERR: state_next = IDLE;

         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers; everything freezes while clk_en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         addr_reg        <= 32'd0;
         wdata_reg       <= 32'd0;
         be_reg          <= 4'b0000;
         we_reg          <= 1'b0;
         cnt_reg         <= 32'd0;
         data_rd_reg     <= 32'd0;
         fault_cause_reg <= 2'b00;
         fault_addr_reg  <= 32'd0;
      end else if (clk_en) begin
         state_reg       <= state_next;
         addr_reg        <= addr_next;
         wdata_reg       <= wdata_next;
         be_reg          <= be_next;
         we_reg          <= we_next;
         cnt_reg         <= cnt_next;
         data_rd_reg     <= data_rd_next;
         fault_cause_reg <= fault_cause_next;
         fault_addr_reg  <= fault_addr_next;
      end
   end

   // Output decode; the IDLE stall is combinational so the pipeline holds at once
   always_comb begin
      o_stall   = ((state_reg == IDLE) && req) || (state_reg == BUSY);
      o_bus_req = (state_reg == BUSY);
      o_fault   = (state_reg == ERR);
      o_data_rd = (state_reg == DONE) ? data_rd_reg : 32'd0;
   end

   assign o_fault_cause = fault_cause_reg;
   assign o_fault_addr  = fault_addr_reg;
   assign o_bus_we      = we_reg;
   assign o_bus_addr    = {addr_reg[31:2], 2'b00};
   assign o_bus_wdata   = wdata_reg;
   assign o_bus_be      = be_reg;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed testbench for data_mem_bridge (timeout set to 4 cycles).
module tb_data_mem_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_en;
   logic [31:0] i_data_addr;
   logic [31:0] i_data_wr;
   logic [1:0]  i_data_rd_en_ctrl;
   logic        i_data_rd_en;
   logic        i_data_wr_en;
   logic [31:0] o_data_rd;
   logic        o_stall;
   logic        o_fault;
   logic [1:0]  o_fault_cause;
   logic [31:0] o_fault_addr;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic [3:0]  o_bus_be;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;
   logic        i_bus_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   data_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .clk_en            (clk_en),
      .i_data_addr       (i_data_addr),
      .i_data_wr         (i_data_wr),
      .i_data_rd_en_ctrl (i_data_rd_en_ctrl),
      .i_data_rd_en      (i_data_rd_en),
      .i_data_wr_en      (i_data_wr_en),
      .o_data_rd         (o_data_rd),
      .o_stall           (o_stall),
      .o_fault           (o_fault),
      .o_fault_cause     (o_fault_cause),
      .o_fault_addr      (o_fault_addr),
      .o_bus_req         (o_bus_req),
      .o_bus_we          (o_bus_we),
      .o_bus_addr        (o_bus_addr),
      .o_bus_wdata       (o_bus_wdata),
      .o_bus_be          (o_bus_be),
      .i_bus_ack         (i_bus_ack),
      .i_bus_rdata       (i_bus_rdata),
      .i_bus_err         (i_bus_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Move to 1ns after the next rising edge; inputs change here, checks follow at +5
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic wr, input logic rd, input logic [1:0] ctrl,
                            input logic [31:0] addr, input logic [31:0] wdat);
      i_data_wr_en      = wr;
      i_data_rd_en      = rd;
      i_data_rd_en_ctrl = ctrl;
      i_data_addr       = addr;
      i_data_wr         = wdat;
   endtask

   task automatic drop_req();
      i_data_wr_en = 1'b0;
      i_data_rd_en = 1'b0;
   endtask

   // Full successful access: ack after ack_wait BUSY cycles without ack
   task automatic do_access(input string tag, input logic wr, input logic rd,
                            input logic [1:0] ctrl, input logic [31:0] addr,
                            input logic [31:0] wdat, input int ack_wait,
                            input logic [31:0] rdat, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
      int stalls;
      next_cycle();
      drive_req(wr, rd, ctrl, addr, wdat);
      #4;
      check({tag, ".idle_stall"}, o_stall, 1);
      check({tag, ".req_latency"}, o_bus_req, 0);
      stalls = int'(o_stall);
      for (int k = 0; k <= ack_wait; k++) begin
         next_cycle();
         #4;
         check({tag, ".busy_req"}, o_bus_req, 1);
         if (k == 0) begin
            check({tag, ".bus_addr"}, o_bus_addr, {addr[31:2], 2'b00});
            check({tag, ".bus_be"}, o_bus_be, exp_be);
            check({tag, ".bus_we"}, o_bus_we, wr);
            if (wr) check({tag, ".bus_wdata"}, o_bus_wdata, exp_wdata);
         end
         stalls += int'(o_stall);
         if (k == ack_wait) begin
            i_bus_ack   = 1'b1;
            i_bus_rdata = rdat;
         end
      end
      next_cycle();
      i_bus_ack   = 1'b0;
      i_bus_rdata = 32'd0;
      drop_req();
      #4;
      check({tag, ".done_data"}, o_data_rd, exp_rd);
      check({tag, ".done_stall"}, o_stall, 0);
      check({tag, ".done_req"}, o_bus_req, 0);
      check({tag, ".done_fault"}, o_fault, 0);
      check({tag, ".stall_cycles"}, stalls, ack_wait + 2);
      $display("txn %s addr=%h we=%0d be=%b rd=%h", tag, addr, wr, exp_be, o_data_rd);
      next_cycle();
      #4;
      check({tag, ".idle_data"}, o_data_rd, 0);
      check({tag, ".idle_req"}, o_bus_req, 0);
   endtask

   // Misaligned or reserved-size request: no bus cycle, fault next cycle
   task automatic do_misaligned(input string tag, input logic wr, input logic rd,
                                input logic [1:0] ctrl, input logic [31:0] addr);
      next_cycle();
      drive_req(wr, rd, ctrl, addr, 32'h5555_AAAA);
      #4;
      check({tag, ".stall"}, o_stall, 1);
      check({tag, ".no_req"}, o_bus_req, 0);
      next_cycle();
      drop_req();
      #4;
      check({tag, ".fault"}, o_fault, 1);
      check({tag, ".cause"}, o_fault_cause, 2'b01);
      check({tag, ".fault_addr"}, o_fault_addr, addr);
      check({tag, ".err_stall"}, o_stall, 0);
      check({tag, ".err_req"}, o_bus_req, 0);
      $display("txn %s addr=%h cause=%b", tag, addr, o_fault_cause);
      next_cycle();
      #4;
      check({tag, ".fault_pulse"}, o_fault, 0);
      check({tag, ".after_req"}, o_bus_req, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      clk_en            = 1'b1;
      i_data_addr       = 32'd0;
      i_data_wr         = 32'd0;
      i_data_rd_en_ctrl = 2'b00;
      i_data_rd_en      = 1'b0;
      i_data_wr_en      = 1'b0;
      i_bus_ack         = 1'b0;
      i_bus_rdata       = 32'd0;
      i_bus_err         = 1'b0;

      // Reset values
      #3;
      check("rst.data_rd", o_data_rd, 0);
      check("rst.stall", o_stall, 0);
      check("rst.fault", o_fault, 0);
      check("rst.cause", o_fault_cause, 0);
      check("rst.fault_addr", o_fault_addr, 0);
      check("rst.req", o_bus_req, 0);
      check("rst.we", o_bus_we, 0);
      check("rst.addr", o_bus_addr, 0);
      check("rst.wdata", o_bus_wdata, 0);
      check("rst.be", o_bus_be, 0);
      next_cycle();
      rst_n = 1'b1;

      // Loads and stores
      do_access("LW10", 1'b0, 1'b1, 2'b10, 32'h0000_0010, 32'd0, 2, 32'h1234_5678,
                4'b1111, 32'd0, 32'h1234_5678);
      do_access("LB13", 1'b0, 1'b1, 2'b00, 32'h0000_0013, 32'd0, 0, 32'hAB00_0000,
                4'b1111, 32'd0, 32'h0000_00AB);
      do_access("LHU12", 1'b0, 1'b1, 2'b01, 32'h0000_0012, 32'd0, 0, 32'hABCD_0000,
                4'b1111, 32'd0, 32'h0000_ABCD);
      do_access("SB", 1'b1, 1'b0, 2'b00, 32'h1000_0001, 32'h0000_00BE, 1, 32'hFFFF_FFFF,
                4'b0010, 32'hBEBE_BEBE, 32'd0);
      do_access("SH", 1'b1, 1'b0, 2'b01, 32'h1000_0002, 32'h0000_BABE, 0, 32'hFFFF_FFFF,
                4'b1100, 32'hBABE_BABE, 32'd0);
      do_access("SW", 1'b1, 1'b0, 2'b10, 32'h1000_0000, 32'hCAFE_BABE, 0, 32'hFFFF_FFFF,
                4'b1111, 32'hCAFE_BABE, 32'd0);
      do_access("RDWR", 1'b1, 1'b1, 2'b00, 32'h0000_0023, 32'h0000_0071, 0, 32'h1122_3344,
                4'b1000, 32'h7171_7171, 32'd0);

      // Alignment faults
      do_misaligned("LW11", 1'b0, 1'b1, 2'b10, 32'h0000_0011);
      do_misaligned("SH13", 1'b1, 1'b0, 2'b01, 32'h0000_0013);
      do_misaligned("RSVD", 1'b0, 1'b1, 2'b11, 32'h0000_0040);

      // Timeout: four BUSY cycles, then cause 10
      next_cycle();
      drive_req(1'b0, 1'b1, 2'b10, 32'h0000_0040, 32'd0);
      #4;
      check("to.stall", o_stall, 1);
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         if (k == 0) drop_req();
         #4;
         check("to.busy_req", o_bus_req, 1);
      end
      next_cycle();
      #4;
      check("to.fault", o_fault, 1);
      check("to.cause", o_fault_cause, 2'b10);
      check("to.fault_addr", o_fault_addr, 32'h0000_0040);
      check("to.req", o_bus_req, 0);
      $display("txn TIMEOUT addr=%h cause=%b", o_fault_addr, o_fault_cause);

      // Bus error together with ack: error wins, no DONE
      next_cycle();
      drive_req(1'b1, 1'b0, 2'b10, 32'h0000_0050, 32'h0BAD_F00D);
      #4;
      next_cycle();
      #4;
      check("be.busy_req", o_bus_req, 1);
      i_bus_ack   = 1'b1;
      i_bus_err   = 1'b1;
      i_bus_rdata = 32'h7777_7777;
      next_cycle();
      i_bus_ack = 1'b0;
      i_bus_err = 1'b0;
      drop_req();
      #4;
      check("be.fault", o_fault, 1);
      check("be.cause", o_fault_cause, 2'b11);
      check("be.fault_addr", o_fault_addr, 32'h0000_0050);
      check("be.data_rd", o_data_rd, 0);
      check("be.stall", o_stall, 0);
      $display("txn BUSERR addr=%h cause=%b", o_fault_addr, o_fault_cause);
      next_cycle();
      #4;
      check("be.no_done", o_data_rd, 0);
      check("be.cause_hold", o_fault_cause, 2'b11);
      check("be.fault_pulse", o_fault, 0);

      // Ack and error outside BUSY are ignored
      next_cycle();
      i_bus_ack   = 1'b1;
      i_bus_err   = 1'b1;
      i_bus_rdata = 32'hFFFF_FFFF;
      #4;
      check("ign.stall", o_stall, 0);
      next_cycle();
      i_bus_ack = 1'b0;
      i_bus_err = 1'b0;
      #4;
      check("ign.fault", o_fault, 0);
      check("ign.data_rd", o_data_rd, 0);
      check("ign.req", o_bus_req, 0);
      $display("txn IGNORE ack/err in idle");

      // Clock enable low during BUSY freezes request, address and counter
      next_cycle();
      drive_req(1'b0, 1'b1, 2'b10, 32'h0000_0060, 32'd0);
      #4;
      next_cycle();
      drop_req();
      #4;
      check("ce.busy_req", o_bus_req, 1);
      clk_en = 1'b0;
      for (int f = 0; f < 6; f++) begin
         next_cycle();
         #4;
         check("ce.held_req", o_bus_req, 1);
         check("ce.held_addr", o_bus_addr, 32'h0000_0060);
      end
      clk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         #4;
         check("ce.resume_req", o_bus_req, 1);
      end
      next_cycle();
      #4;
      check("ce.fault", o_fault, 1);
      check("ce.cause", o_fault_cause, 2'b10);
      check("ce.fault_addr", o_fault_addr, 32'h0000_0060);
      $display("txn CLKEN addr=%h cause=%b", o_fault_addr, o_fault_cause);

      // Asynchronous reset in the middle of BUSY
      next_cycle();
      drive_req(1'b1, 1'b0, 2'b00, 32'h0000_0071, 32'h0000_00EE);
      #4;
      next_cycle();
      drop_req();
      #4;
      check("ar.busy_req", o_bus_req, 1);
      rst_n = 1'b0;
      #1;
      check("ar.req", o_bus_req, 0);
      check("ar.stall", o_stall, 0);
      check("ar.be", o_bus_be, 0);
      check("ar.we", o_bus_we, 0);
      check("ar.addr", o_bus_addr, 0);
      check("ar.wdata", o_bus_wdata, 0);
      check("ar.cause", o_fault_cause, 0);
      check("ar.fault_addr", o_fault_addr, 0);
      $display("txn ASYNC_RESET mid-busy");
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      #4;
      check("ar.no_retry", o_bus_req, 0);
      do_access("LW_after_rst", 1'b0, 1'b1, 2'b10, 32'h0000_0010, 32'd0, 1, 32'hDEAD_BEEF,
                4'b1111, 32'd0, 32'hDEAD_BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
